// File: rtl/cmos_pkg.sv
// Shared definitions for the CMOS capture path: FSM encoding, default sensor geometry,
// and width helpers used by cmos_capture_win and cmos_pix_pack.
package cmos_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_SKIP    = 2'd2,
        ST_CAPTURE = 2'd3
    } cap_state_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    function automatic int pix_w(input int data_w, input int bytes_per_pix);
        return data_w * bytes_per_pix;
    endfunction

    // Counter width that stays at least one bit for a modulus of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmos_pix_pack.sv
// Assembles BYTES_PER_PIX bus beats into one pixel, first beat in the MSBs, and
// flags a partial pixel when the line ends between beats.
module cmos_pix_pack
    import cmos_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int PIX_W         = DATA_W * BYTES_PER_PIX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              beat,
    input  logic              line_end,
    input  logic [DATA_W-1:0] data_in,
    output logic              pix_done,
    output logic [PIX_W-1:0]  pix_data,
    output logic              partial
);

    localparam int             CW   = cnt_w(BYTES_PER_PIX);
    localparam logic [CW-1:0]  LAST = CW'(BYTES_PER_PIX - 1);

    logic [CW-1:0]    cnt_d, cnt_q;
    logic [PIX_W-1:0] acc_d, acc_q;
    logic [PIX_W-1:0] shifted;

    always_comb begin
        shifted  = (acc_q << DATA_W) | PIX_W'(data_in);
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        pix_done = 1'b0;
        partial  = 1'b0;
        // clear has priority so a frame start on the same cycle as a line end wins
        if (clear) begin
            cnt_d = '0;
        end else if (beat) begin
            acc_d = shifted;
            if (cnt_q == LAST) begin
                cnt_d    = '0;
                pix_done = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (line_end) begin
            partial = (cnt_q != '0);
            cnt_d   = '0;
        end
    end

    assign pix_data = shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/cmos_capture_win.sv
// DVP capture top: input registering, settle-frame skip FSM, crop window and pixel strobes.
// CMOS_VALID is a one-cycle strobe with no ready; the consumer must accept every strobe.
// Optional frame-rate counter is built when CMOS_CAPTURE_FPS_EN is defined.
module cmos_capture_win
    import cmos_pkg::*;
#(
    parameter int   DATA_W        = 8,
    parameter int   BYTES_PER_PIX = 2,
    parameter int   XW            = 11,
    parameter int   YW            = 10,
    parameter int   SKIP_FRAMES   = 10,
    parameter logic VS_POL        = 1'b1,
    localparam int  PIX_W         = pix_w(DATA_W, BYTES_PER_PIX)
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              Init_Done,
    input  logic              CMOS_VSYNC,
    input  logic              CMOS_HREF,
    input  logic [DATA_W-1:0] CMOS_iDATA,
    input  logic [XW-1:0]     iX0,
    input  logic [XW-1:0]     iW,
    input  logic [YW-1:0]     iY0,
    input  logic [YW-1:0]     iH,
    input  logic              iSEC_TICK,
    output logic [PIX_W-1:0]  CMOS_oDATA,
    output logic              CMOS_VALID,
    output logic              oSOF,
    output logic              oEOF,
    output logic              oLINE_ERR,
    output logic [7:0]        oFPS
);

    localparam int            SKW   = $clog2(SKIP_FRAMES + 2);
    localparam logic [XW-1:0] X_MAX = '1;
    localparam logic [YW-1:0] Y_MAX = '1;

    logic              vs_r1_d, vs_r1_q, vs_r2_d, vs_r2_q;
    logic              href_r1_d, href_r1_q, href_r2_d, href_r2_q;
    logic [DATA_W-1:0] data_r1_d, data_r1_q;

    cap_state_e        state_d, state_q;
    logic [SKW-1:0]    skip_d, skip_q;
    logic [XW-1:0]     x_d, x_q, x0_d, x0_q, w_d, w_q;
    logic [YW-1:0]     y_d, y_q, y0_d, y0_q, h_d, h_q;
    logic              emitted_d, emitted_q;
    logic [PIX_W-1:0]  data_d, data_q;
    logic              valid_d, valid_q, sof_d, sof_q, eof_d, eof_q, lerr_d, lerr_q;

    logic              frame_start, frame_end, href_fall, active, pack_clear;
    logic              x_hit, y_hit;
    logic              pix_done, pix_partial;
    logic [PIX_W-1:0]  pix_data;

    always_comb begin
        vs_r1_d   = CMOS_VSYNC;
        vs_r2_d   = vs_r1_q;
        href_r1_d = CMOS_HREF;
        href_r2_d = href_r1_q;
        data_r1_d = CMOS_iDATA;
    end

    assign frame_start = (vs_r1_q != VS_POL) && (vs_r2_q == VS_POL);
    assign frame_end   = (vs_r1_q == VS_POL) && (vs_r2_q != VS_POL);
    assign href_fall   = href_r2_q && !href_r1_q;
    assign active      = (state_q == ST_SKIP) || (state_q == ST_CAPTURE);
    assign pack_clear  = !Init_Done || (state_q == ST_IDLE) || frame_start;

    // Widened by one bit so X0+W past the counter range cannot wrap into a hit.
    assign x_hit = ({1'b0, x_q} >= {1'b0, x0_q}) && ({1'b0, x_q} < ({1'b0, x0_q} + {1'b0, w_q}));
    assign y_hit = ({1'b0, y_q} >= {1'b0, y0_q}) && ({1'b0, y_q} < ({1'b0, y0_q} + {1'b0, h_q}));

    cmos_pix_pack #(
        .DATA_W        (DATA_W),
        .BYTES_PER_PIX (BYTES_PER_PIX),
        .PIX_W         (PIX_W)
    ) u_pack (
        .clk      (iCLK),
        .rst_n    (iRST_N),
        .clear    (pack_clear),
        .beat     (href_r1_q),
        .line_end (href_fall),
        .data_in  (data_r1_q),
        .pix_done (pix_done),
        .pix_data (pix_data),
        .partial  (pix_partial)
    );

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        case (state_q)
            ST_IDLE: begin
                if (Init_Done) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (frame_start) begin
                    if (SKIP_FRAMES == 0) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d = ST_SKIP;
                        skip_d  = SKW'(SKIP_FRAMES);
                    end
                end
            end
            ST_SKIP: begin
                // The count covers the frame being skipped, so leave when it would reach 0.
                if (frame_start) begin
                    if (skip_q <= SKW'(1)) begin
                        state_d = ST_CAPTURE;
                        skip_d  = '0;
                    end else begin
                        skip_d = skip_q - SKW'(1);
                    end
                end
            end
            ST_CAPTURE: begin
                state_d = ST_CAPTURE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!Init_Done) begin
            state_d = ST_IDLE;
            skip_d  = '0;
        end
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        x0_d      = x0_q;
        w_d       = w_q;
        y0_d      = y0_q;
        h_d       = h_q;
        emitted_d = emitted_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        lerr_d    = 1'b0;
        if (!Init_Done || (state_q == ST_IDLE)) begin
            x_d       = '0;
            y_d       = '0;
            emitted_d = 1'b0;
        end else if (frame_start) begin
            x_d       = '0;
            y_d       = '0;
            emitted_d = 1'b0;
            x0_d      = iX0;
            w_d       = iW;
            y0_d      = iY0;
            h_d       = iH;
        end else begin
            if (pix_done) begin
                if (x_q != X_MAX) x_d = x_q + XW'(1);
                if ((state_q == ST_CAPTURE) && x_hit && y_hit) begin
                    valid_d   = 1'b1;
                    data_d    = pix_data;
                    sof_d     = !emitted_q;
                    emitted_d = 1'b1;
                end
            end
            if (href_fall) begin
                x_d    = '0;
                lerr_d = pix_partial && active;
                if (y_q != Y_MAX) y_d = y_q + YW'(1);
            end
            if (frame_end && (state_q == ST_CAPTURE) && emitted_q) eof_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vs_r1_q   <= ~VS_POL;
            vs_r2_q   <= ~VS_POL;
            href_r1_q <= 1'b0;
            href_r2_q <= 1'b0;
            data_r1_q <= '0;
            state_q   <= ST_IDLE;
            skip_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            x0_q      <= '0;
            w_q       <= '0;
            y0_q      <= '0;
            h_q       <= '0;
            emitted_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            lerr_q    <= 1'b0;
        end else begin
            vs_r1_q   <= vs_r1_d;
            vs_r2_q   <= vs_r2_d;
            href_r1_q <= href_r1_d;
            href_r2_q <= href_r2_d;
            data_r1_q <= data_r1_d;
            state_q   <= state_d;
            skip_q    <= skip_d;
            x_q       <= x_d;
            y_q       <= y_d;
            x0_q      <= x0_d;
            w_q       <= w_d;
            y0_q      <= y0_d;
            h_q       <= h_d;
            emitted_q <= emitted_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            lerr_q    <= lerr_d;
        end
    end

    assign CMOS_oDATA = data_q;
    assign CMOS_VALID = valid_q;
    assign oSOF       = sof_q;
    assign oEOF       = eof_q;
    assign oLINE_ERR  = lerr_q;

`ifdef CMOS_CAPTURE_FPS_EN
    logic [7:0] fcnt_d, fcnt_q, fps_d, fps_q, fcnt_inc;

    // An EOF coinciding with the tick is folded into the reported value.
    always_comb begin
        fcnt_inc = (eof_q && (fcnt_q != 8'hFF)) ? fcnt_q + 8'd1 : fcnt_q;
        fcnt_d   = fcnt_inc;
        fps_d    = fps_q;
        if (iSEC_TICK) begin
            fps_d  = fcnt_inc;
            fcnt_d = 8'd0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            fcnt_q <= 8'd0;
            fps_q  <= 8'd0;
        end else begin
            fcnt_q <= fcnt_d;
            fps_q  <= fps_d;
        end
    end

    assign oFPS = fps_q;
`else
    logic sec_tick_unused;
    assign sec_tick_unused = iSEC_TICK;
    assign oFPS            = 8'd0;
`endif

endmodule

// File: tb/tb_cmos_capture_win.sv
// Self-checking bench for cmos_capture_win: table-driven crop windows, random frames
// against a frame-level reference model, and hand sequences for reset/Init_Done/FPS corners.
module tb_cmos_capture_win;

    localparam int SKIP = 2;
    localparam int COLS = 16;
    localparam int ROWS = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic        vsync;
    logic        href;
    logic [7:0]  din;
    logic [10:0] x0, w;
    logic [9:0]  y0, h;
    logic        sec_tick;
    logic [15:0] dout;
    logic        valid, sof, eof, lerr;
    logic [7:0]  fps;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp_pix;
    logic [15:0] first_data;
    logic        prev_valid = 1'b0;
    int valid_cnt, sof_cnt, eof_cnt, lerr_cnt;
    int frames_since_init;
    int opt_odd_row  = -1;
    int opt_wchg_row = -1;
    int opt_wchg_val = 0;
    int opt_drop_row = -1;
    bit opt_rnd      = 1'b0;

    typedef struct {
        int          x0;
        int          w;
        int          y0;
        int          h;
        int          exp_cnt;
        logic [15:0] exp_first;
    } vec_t;
    vec_t vecs[7];

    cmos_capture_win #(
        .DATA_W        (8),
        .BYTES_PER_PIX (2),
        .XW            (11),
        .YW            (10),
        .SKIP_FRAMES   (SKIP),
        .VS_POL        (1'b1)
    ) dut (
        .iCLK       (clk),
        .iRST_N     (rst_n),
        .Init_Done  (init_done),
        .CMOS_VSYNC (vsync),
        .CMOS_HREF  (href),
        .CMOS_iDATA (din),
        .iX0        (x0),
        .iW         (w),
        .iY0        (y0),
        .iH         (h),
        .iSEC_TICK  (sec_tick),
        .CMOS_oDATA (dout),
        .CMOS_VALID (valid),
        .oSOF       (sof),
        .oEOF       (eof),
        .oLINE_ERR  (lerr),
        .oFPS       (fps)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
        end
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                valid_cnt++;
                chk("valid_spacing", {31'd0, prev_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got 0x%0h, expected no strobe", dout);
                end else begin
                    exp_pix = exp_q.pop_front();
                    chk("pixel_data", {16'd0, dout}, {16'd0, exp_pix});
                end
            end
            if (sof) begin
                sof_cnt++;
                first_data = dout;
                chk("sof_with_valid", {31'd0, valid}, 32'd1);
            end
            if (eof)  eof_cnt++;
            if (lerr) lerr_cnt++;
            prev_valid = valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // driver + reference model: one frame of `rows` lines of `cols` 2-byte pixels
    task automatic run_frame(input int cols, input int rows, input string tag, output int n_exp);
        logic [7:0] b0, bv;
        bit cap;
        int ax0, aw, ay0, ah, beats, px;
        int exp_lerr;
        valid_cnt = 0;
        sof_cnt   = 0;
        eof_cnt   = 0;
        lerr_cnt  = 0;
        n_exp     = 0;
        b0        = 8'd0;
        vsync     = 1'b0;
        if (init_done) frames_since_init++;
        cap = init_done && (frames_since_init > SKIP);
        ax0 = int'(x0); aw = int'(w); ay0 = int'(y0); ah = int'(h);
        step(3);
        for (int r = 0; r < rows; r++) begin
            if (r == opt_wchg_row) w = 11'(opt_wchg_val);
            href  = 1'b1;
            beats = 2 * cols + ((r == opt_odd_row) ? 1 : 0);
            for (int b = 0; b < beats; b++) begin
                if (r == opt_drop_row && b == cols) begin
                    init_done         = 1'b0;
                    frames_since_init = 0;
                    cap               = 1'b0;
                    n_exp             = n_exp - exp_q.size();
                    exp_q.delete();
                end
                bv  = opt_rnd ? 8'($urandom) : 8'(b);
                din = bv;
                px  = b / 2;
                if (b % 2 == 0) begin
                    b0 = bv;
                end else if (cap && px >= ax0 && px < ax0 + aw && r >= ay0 && r < ay0 + ah) begin
                    exp_q.push_back({b0, bv});
                    n_exp++;
                end
                step(1);
                if (r == opt_drop_row && b == cols) chk("drop_valid_low", {31'd0, valid}, 32'd0);
            end
            href = 1'b0;
            din  = 8'd0;
            step(4);
        end
        vsync = 1'b1;
        step(5);
        exp_lerr = (opt_odd_row >= 0 && init_done && frames_since_init >= 1) ? 1 : 0;
        chk({tag, "_count"}, valid_cnt, n_exp);
        chk({tag, "_sof"}, sof_cnt, (n_exp > 0) ? 1 : 0);
        chk({tag, "_eof"}, eof_cnt, (n_exp > 0 && init_done) ? 1 : 0);
        chk({tag, "_line_err"}, lerr_cnt, exp_lerr);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic set_win(input int ax0, input int aw, input int ay0, input int ah);
        x0 = 11'(ax0);
        w  = 11'(aw);
        y0 = 10'(ay0);
        h  = 10'(ah);
    endtask

    initial begin
        int n;
        vecs[0] = '{10, 4,  2, 3, 12, 16'h1415};
        vecs[1] = '{0,  16, 0, 6, 96, 16'h0001};
        vecs[2] = '{0,  0,  0, 6, 0,  16'h0000};
        vecs[3] = '{0,  16, 0, 0, 0,  16'h0000};
        vecs[4] = '{14, 10, 5, 5, 2,  16'h1c1d};
        vecs[5] = '{15, 1,  0, 1, 1,  16'h1e1f};
        vecs[6] = '{3,  2,  4, 2, 4,  16'h0607};

        rst_n = 1'b0; init_done = 1'b0; vsync = 1'b1; href = 1'b0; din = 8'd0;
        sec_tick = 1'b0; frames_since_init = 0;
        set_win(0, COLS, 0, ROWS);
        step(5);
        chk("rst_data",  {16'd0, dout}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_sof",   {31'd0, sof}, 32'd0);
        chk("rst_eof",   {31'd0, eof}, 32'd0);
        chk("rst_lerr",  {31'd0, lerr}, 32'd0);
        chk("rst_fps",   {24'd0, fps}, 32'd0);
        rst_n = 1'b1;
        step(2);

        // reset asserted mid-line with Init_Done already high
        init_done = 1'b1;
        step(2);
        valid_cnt = 0;
        vsync = 1'b0;
        step(3);
        href = 1'b1;
        for (int b = 0; b < 10; b++) begin din = 8'(b); step(1); end
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        frames_since_init = 0;
        for (int b = 10; b < 20; b++) begin din = 8'(b); step(1); end
        href = 1'b0;
        step(4);
        vsync = 1'b1;
        step(5);
        chk("rst_mid_no_pixels", valid_cnt, 0);

        for (int i = 0; i < 3; i++) begin
            run_frame(COLS, ROWS, "skip", n);
            chk("skip_seq_count", valid_cnt, (i == 2) ? 96 : 0);
        end

        foreach (vecs[i]) begin
            set_win(vecs[i].x0, vecs[i].w, vecs[i].y0, vecs[i].h);
            run_frame(COLS, ROWS, "vec", n);
            chk("vec_table_count", valid_cnt, vecs[i].exp_cnt);
            if (vecs[i].exp_cnt > 0) chk("vec_first_data", {16'd0, first_data}, {16'd0, vecs[i].exp_first});
        end

        set_win(0, COLS, 0, ROWS);
        opt_odd_row = 2;
        run_frame(COLS, ROWS, "odd_line", n);
        opt_odd_row = -1;
        chk("odd_line_pulses", lerr_cnt, 1);

        set_win(0, 4, 0, ROWS);
        opt_wchg_row = 3;
        opt_wchg_val = 8;
        run_frame(COLS, ROWS, "wchg_cur", n);
        opt_wchg_row = -1;
        chk("wchg_cur_uses_old", valid_cnt, 24);
        run_frame(COLS, ROWS, "wchg_next", n);
        chk("wchg_next_uses_new", valid_cnt, 48);

        opt_rnd = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_win($urandom_range(0, 12), $urandom_range(0, 8), $urandom_range(0, 5), $urandom_range(0, 4));
            run_frame(COLS, ROWS, "rand", n);
        end
        opt_rnd = 1'b0;

        set_win(0, COLS, 0, ROWS);
        opt_drop_row = 2;
        run_frame(COLS, ROWS, "drop", n);
        opt_drop_row = -1;
        chk("drop_count", valid_cnt, 39);
        init_done = 1'b1;
        frames_since_init = 0;
        step(2);
        for (int i = 0; i < 3; i++) begin
            run_frame(COLS, ROWS, "reskip", n);
            chk("reskip_seq_count", valid_cnt, (i == 2) ? 96 : 0);
        end

        set_win(0, 2, 0, 1);
        sec_tick = 1'b1;
        step(1);
        sec_tick = 1'b0;
        for (int i = 0; i < 30; i++) run_frame(2, 1, "fps_frame", n);
        sec_tick = 1'b1;
        step(1);
        sec_tick = 1'b0;
`ifdef CMOS_CAPTURE_FPS_EN
        chk("fps_value", {24'd0, fps}, 32'd30);
`else
        chk("fps_value", {24'd0, fps}, 32'd0);
`endif

        step(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
